micro_sequencer: RTL
====================

# micro_sequencer

Parametrised microprogrammed control unit for the accumulator CPU. It holds a writable control store and a writable opcode-dispatch map. Each cycle it sequences a control-address register (CAR) with increment, opcode dispatch, conditional branch on ALU flags, and halt/resume. It drives one registered control word per cycle to the datapath: MAR, MBR, PC, IR, ACC, BR and the ALU.

## Interface
Parameters:
- OPCODE_W, 8, opcode width; the dispatch map has 2**OPCODE_W entries
- CAR_W, 8, control-address width; the control store has 2**CAR_W microwords
- CTRL_W, 32, control-signal width
- FLAG_W, 8, flag-vector width; must be at least 2
- Derived: SEL_W = $clog2(FLAG_W); UW_W = CTRL_W + CAR_W + SEL_W + 4

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- step_en  in  1  advance enable; when low the sequencer freezes (memory wait)
- resume  in  1  leave the halted state
- opcode  in  OPCODE_W  current IR opcode
- flags  in  FLAG_W  ALU/status flags
- us_we  in  1  control-store write enable
- us_waddr  in  CAR_W  control-store write address
- us_wdata  in  UW_W  microword to write
- map_we  in  1  dispatch-map write enable
- map_waddr  in  OPCODE_W  opcode to map
- map_wdata  in  CAR_W  entry address for that opcode
- control_signal  out  CTRL_W  registered control word to the datapath
- car  out  CAR_W  current control address
- halted  out  1  sequencer is halted

## Operation
- Microword fields, listed LSB first:
  - ctrl[CTRL_W]
  - target[CAR_W]
  - sel[SEL_W]
  - cond[2]
  - seq[2]
- Current word: uw = store[car], read combinationally.
- seq codes:
  - 00 INC: car <= car+1
  - 01 MAP: car <= map[opcode]
  - 10 BR: car <= target if the condition holds, else car+1
  - 11 HALT: car holds; halted <= 1
- cond codes, used by BR only:
  - 00 always
  - 01 branch if flags[sel]==1
  - 10 branch if flags[sel]==0
  - 11 never
- If sel >= FLAG_W, the selected flag reads as 0.
- car+1 wraps from 2**CAR_W-1 to 0 (modulo 2**CAR_W).
- Running with step_en=1: control_signal <= uw.ctrl and car updates per seq, both on the same edge.
- step_en=0 with halted=0: car and control_signal hold.
- Halted:
  - control_signal <= 0 and car holds.
  - If resume=1 and step_en=1: halted <= 0 and car <= car+1.
  - The resume edge still drives control_signal 0.
- Write ports work in any state, including halted and step_en=0.
  - A write lands at the clock edge.
  - A same-cycle read of the same address returns the old contents.
  - us_we and map_we may both be asserted in the same cycle.
- Reset, asserted at any time including mid-microroutine:
  - car=0, control_signal=0, halted=0
  - every control-store word=0; every map entry=0
  - An all-zero microword is "INC, no controls", so the store is safe until loaded.
- Unmapped opcodes dispatch to address 0 (restart fetch).

## Timing
- One microword per enabled cycle.
- control_signal lags the word at car by one cycle: the word at car=A during cycle n appears on control_signal in cycle n+1.
- MAP and BR take effect at the next edge; there is no delay slot.
- The ctrl bits of a HALT word are emitted exactly once, on the edge that sets halted.
- resume is level-sampled and needs only one cycle with step_en=1.
- halted rises on the edge after the HALT word is executed.
- Write-to-use latency is 1 cycle: a word written at edge k is executable from cycle k+1.
- Release of rst is synchronous to clk; the first microword executes on the first edge after release.

## Test plan
- Reset, then idle with step_en=1:
  - control_signal=0, car increments 0,1,2…, halted=0.
  - Reset asserted mid-run returns all outputs to 0 immediately, without waiting for a clock.
- Fetch/dispatch: load store[0..3] = INC ctrl 0x20, INC ctrl 0x10, INC ctrl 0x2000, MAP; set map[0x03]=0x18; opcode=0x03.
  - control_signal goes 0x20, 0x10, 0x2000, 0x0.
  - car goes 0,1,2,3, then 0x18.
- Conditional branch: store[0x28] = BR cond=01 sel=7 target=0x30.
  - flags=0x80: car goes to 0x30.
  - flags=0x00: car goes to 0x29.
  - Repeat with cond=10 and expect the opposite outcome; cond=11 always gives 0x29.
- Halt/resume: store[0x38] = HALT ctrl 0xFF.
  - 0xFF is emitted once, then control_signal=0 and halted=1 with car=0x38 held.
  - Resume with step_en=0: nothing happens.
  - Resume with step_en=1: halted=0, car=0x39.
- Stall and wrap:
  - step_en=0 for 3 cycles mid-routine: car and control_signal are frozen.
  - INC at car=0xFF: car goes to 0x00.
- Write collision: write store[car] on the same edge it executes.
  - The old word is executed.
  - The new word executes when that address is next visited.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: writable control store and opcode-dispatch map,
// CAR sequencing (increment, dispatch, conditional branch, halt/resume), registered control word.
module micro_sequencer #(
    parameter int OPCODE_W = 8,
    parameter int CAR_W    = 8,
    parameter int CTRL_W   = 32,
    parameter int FLAG_W   = 8,
    localparam int SEL_W   = $clog2(FLAG_W),
    localparam int UW_W    = CTRL_W + CAR_W + SEL_W + 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_en,
    input  logic                resume,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FLAG_W-1:0]   flags,
    input  logic                us_we,
    input  logic [CAR_W-1:0]    us_waddr,
    input  logic [UW_W-1:0]     us_wdata,
    input  logic                map_we,
    input  logic [OPCODE_W-1:0] map_waddr,
    input  logic [CAR_W-1:0]    map_wdata,
    output logic [CTRL_W-1:0]   control_signal,
    output logic [CAR_W-1:0]    car,
    output logic                halted
);

    localparam logic [1:0] SEQ_INC  = 2'b00;
    localparam logic [1:0] SEQ_MAP  = 2'b01;
    localparam logic [1:0] SEQ_BR   = 2'b10;
    localparam logic [1:0] SEQ_HALT = 2'b11;

    localparam logic [1:0] COND_ALWAYS = 2'b00;
    localparam logic [1:0] COND_SET    = 2'b01;
    localparam logic [1:0] COND_CLR    = 2'b10;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    state_t              state_r;
    logic [CAR_W-1:0]    car_r;
    logic [CTRL_W-1:0]   ctrl_r;
    logic [UW_W-1:0]     store_r [2**CAR_W];
    logic [CAR_W-1:0]    map_r   [2**OPCODE_W];

    logic [UW_W-1:0]     uw_s;
    logic [CTRL_W-1:0]   ctrl_s;
    logic [CAR_W-1:0]    target_s;
    logic [SEL_W-1:0]    sel_s;
    logic [1:0]          cond_s;
    logic [1:0]          seq_s;
    logic [CAR_W-1:0]    car_inc_s;
    logic                flag_sel_s;
    logic                br_take_s;

    assign uw_s      = store_r[car_r];
    assign ctrl_s    = uw_s[CTRL_W-1:0];
    assign target_s  = uw_s[CTRL_W +: CAR_W];
    assign sel_s     = uw_s[CTRL_W+CAR_W +: SEL_W];
    assign cond_s    = uw_s[CTRL_W+CAR_W+SEL_W +: 2];
    assign seq_s     = uw_s[CTRL_W+CAR_W+SEL_W+2 +: 2];
    assign car_inc_s = car_r + CAR_W'(1);

    assign control_signal = ctrl_r;
    assign car            = car_r;
    assign halted         = (state_r == ST_HALTED);

    // Flag mux; a select beyond the implemented flags matches no bit and reads 0.
    always_comb begin
        flag_sel_s = 1'b0;
        for (int i = 0; i < FLAG_W; i++) begin
            flag_sel_s = flag_sel_s | (flags[i] & (sel_s == SEL_W'(i)));
        end
    end

    // Branch condition decode.
    always_comb begin
        br_take_s = 1'b0;
        case (cond_s)
            COND_ALWAYS: br_take_s = 1'b1;
            COND_SET:    br_take_s = flag_sel_s;
            COND_CLR:    br_take_s = ~flag_sel_s;
            default:     br_take_s = 1'b0;
        endcase
    end

    // Control store: cleared on reset so every word decodes as INC with no controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**CAR_W; i++) begin
                store_r[i] <= '0;
            end
        end else if (us_we) begin
            store_r[us_waddr] <= us_wdata;
        end
    end

    // Dispatch map: cleared on reset so unmapped opcodes restart at address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2**OPCODE_W; i++) begin
                map_r[i] <= '0;
            end
        end else if (map_we) begin
            map_r[map_waddr] <= map_wdata;
        end
    end

    // Sequencer FSM: CAR update, control word and halt state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
            car_r   <= '0;
            ctrl_r  <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (step_en) begin
                        ctrl_r <= ctrl_s;
                        case (seq_s)
                            SEQ_INC:  car_r   <= car_inc_s;
                            SEQ_MAP:  car_r   <= map_r[opcode];
                            SEQ_BR:   car_r   <= br_take_s ? target_s : car_inc_s;
                            SEQ_HALT: state_r <= ST_HALTED;
                            default:  car_r   <= car_inc_s;
                        endcase
                    end
                end
                ST_HALTED: begin
                    // The HALT word's controls went out on the entering edge; stay quiet here.
                    ctrl_r <= '0;
                    if (resume && step_en) begin
                        state_r <= ST_RUN;
                        car_r   <= car_inc_s;
                    end
                end
                default: begin
                    state_r <= ST_RUN;
                    ctrl_r  <= '0;
                end
            endcase
        end
    end

endmodule
